uart_rx_buffer: RTL
===================

UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

Interface
REQ-001 Parameter DataBits, default 8, width of received data word (5..9).
REQ-002 Parameter Depth, default 16, FIFO entries (power of two, >= 2).
REQ-003 Parameter Watermark, default 12, level at or above which almost_full asserts (1..Depth).
REQ-004 Parameter TimeoutCycles, default 512, idle clk cycles before char_timeout asserts (>= 2).
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 rx_data  input  DataBits  received word from receiver stage.
REQ-008 rx_valid  input  1  single-cycle pulse: rx_data is a good frame.
REQ-009 rx_break  input  1  single-cycle pulse: break condition received.
REQ-010 rx_error  input  1  single-cycle pulse: framing/parity error frame.
REQ-011 m_data  output  DataBits  head-entry data.
REQ-012 m_error  output  1  head entry carries error flag.
REQ-013 m_break  output  1  head entry carries break flag.
REQ-014 m_valid  output  1  head entry present.
REQ-015 m_ready  input  1  consumer accepts head when m_valid high.
REQ-016 level  output  $clog2(Depth+1)  current entry count.
REQ-017 almost_full  output  1  level >= Watermark.
REQ-018 overflow  output  1  sticky: at least one entry dropped.
REQ-019 overflow_clear  input  1  clears overflow.
REQ-020 char_timeout  output  1  data waiting and receiver idle for TimeoutCycles.

Function
REQ-021 A push SHALL occur in any cycle where rx_valid, rx_break or rx_error is high and (level < Depth or a pop occurs the same cycle).
REQ-022 Multiple inputs high in one cycle SHALL produce exactly one entry, flags priority break > error > valid; break entry stores data 0, error=0, break=1.
REQ-023 Error entry SHALL store rx_data with error=1; valid entry stores rx_data with both flags 0.
REQ-024 A pop SHALL occur when m_valid && m_ready; m_* SHALL be combinationally driven from the head entry (show-ahead).
REQ-025 Push at edge N SHALL make the entry visible on m_* after edge N (zero-wait, one-edge latency); empty-FIFO push+pop same cycle is not possible (m_valid low).
REQ-026 Push and pop in the same cycle SHALL leave level unchanged, including when full.
REQ-027 Push attempt when full without simultaneous pop SHALL drop the word, leave contents unchanged and set overflow at the next edge.
REQ-028 overflow SHALL remain set until overflow_clear is sampled high; a drop in the same cycle as overflow_clear SHALL leave overflow set.
REQ-029 Read/write pointers SHALL wrap modulo Depth; level SHALL range 0..Depth exactly.
REQ-030 Idle counter SHALL reset to 0 on any push, any pop, or level==0, and otherwise increment saturating at TimeoutCycles.
REQ-031 char_timeout SHALL be high while counter == TimeoutCycles and level > 0, falling the cycle after the next push or pop.
REQ-032 m_valid, almost_full and level SHALL be registered-state derived with no combinational path from rx_* inputs.

Reset
REQ-033 rst SHALL clear pointers, level, overflow and idle counter asynchronously; outputs after reset: m_valid=0, level=0, almost_full=0, overflow=0, char_timeout=0.
REQ-034 Reset mid-operation SHALL discard all stored entries; storage array contents need not be cleared.

Structure
REQ-035 A typedef for the entry record (data, error, break) and flag-priority constants SHALL live in shared package uart_pkg.
REQ-036 Storage and pointers SHALL be one sub-module, sync_fifo (Width, Depth parameters, show-ahead, push/pop/full/empty/level); flag encoding, overflow and timeout logic stay in uart_rx_buffer.

Verification
REQ-037 Push 0x41,0x42,0x43 with m_ready=0 -> level=3, m_data=0x41; raise m_ready 3 cycles -> 0x41,0x42,0x43 in order, m_valid falls, level=0.
REQ-038 Fill 16 entries, push 0x55 -> overflow=1, level=16, 0x55 never output; pulse overflow_clear -> overflow=0.
REQ-039 Full FIFO, push 0x77 with m_ready=1 same cycle -> level stays 16, overflow=0, 0x77 emerges last.
REQ-040 rx_break and rx_valid high together with rx_data=0xAA -> single entry data=0x00, m_break=1, m_error=0.
REQ-041 TimeoutCycles=8, push one word, hold m_ready=0 -> char_timeout rises exactly 8 cycles after push, clears after pop.
REQ-042 Assert rst with level=5 mid-burst -> m_valid=0, level=0, overflow=0 immediately, next push appears as sole entry.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types for the UART receive path.
//   rx_entry_t  - one buffered receive record (break flag, error flag, data).
//   rx_src_t    - which receiver pulse produced an entry; the numeric order
//                 of the encoding is the flag priority (break > error > valid).
//   rx_src_sel  - resolves simultaneous receiver pulses to a single source.
package uart_pkg;

  // Widest supported character; narrower builds leave the top bits zero.
  localparam int MaxDataBits = 9;

  typedef struct packed {
    logic                   brk;
    logic                   err;
    logic [MaxDataBits-1:0] data;
  } rx_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_VALID = 2'd1,
    SRC_ERROR = 2'd2,
    SRC_BREAK = 2'd3
  } rx_src_t;

  function automatic rx_src_t rx_src_sel(input logic brk, input logic err, input logic vld);
    if (brk)      return SRC_BREAK;
    else if (err) return SRC_ERROR;
    else if (vld) return SRC_VALID;
    else          return SRC_NONE;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO.
//   clk, rst  - clock, asynchronous active-high reset (pointers/count only)
//   push_i    - write wdata_i (ignored when full unless pop_i same cycle)
//   wdata_i   - write data
//   pop_i     - consume head entry (ignored when empty)
//   rdata_o   - head entry, valid whenever empty_o is low
//   full_o, empty_o, level_o - occupancy status (level 0..Depth)
module sync_fifo #(
  parameter int Width = 8,
  parameter int Depth = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] level_o
);

  localparam int AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Storage is not reset; the count alone decides what is live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: receive FIFO between a UART receiver and its consumer.
//   clk, rst                    - clock, asynchronous active-high reset
//   rx_data/valid/break/error   - single-cycle pulses from the receiver
//   m_data/error/break/valid    - show-ahead head entry, m_ready pops it
//   level, almost_full          - occupancy and watermark flag
//   overflow, overflow_clear    - sticky drop indication and its clear
//   char_timeout                - data waiting while receiver idle
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int DataBits      = 8,
  parameter int Depth         = 16,
  parameter int Watermark     = 12,
  parameter int TimeoutCycles = 512
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DataBits-1:0]        rx_data,
  input  logic                       rx_valid,
  input  logic                       rx_break,
  input  logic                       rx_error,
  output logic [DataBits-1:0]        m_data,
  output logic                       m_error,
  output logic                       m_break,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(Depth+1)-1:0] level,
  output logic                       almost_full,
  output logic                       overflow,
  input  logic                       overflow_clear,
  output logic                       char_timeout
);

  localparam int LW = $clog2(Depth+1);
  localparam int TW = $clog2(TimeoutCycles+1);

  rx_src_t   src;
  rx_entry_t wr_entry, rd_entry;
  logic      full, empty, push_req, push, pop, drop;
  logic      overflow_q, overflow_d;
  logic [TW-1:0] idle_q, idle_d;
  logic      unused_rd;

  assign src = rx_src_sel(rx_break, rx_error, rx_valid);

  // Break entries carry no data; error/valid entries keep the received word.
  always_comb begin
    wr_entry = '0;
    case (src)
      SRC_BREAK: wr_entry.brk = 1'b1;
      SRC_ERROR: begin
        wr_entry.err                = 1'b1;
        wr_entry.data[DataBits-1:0] = rx_data;
      end
      SRC_VALID: wr_entry.data[DataBits-1:0] = rx_data;
      default:   wr_entry = '0;
    endcase
  end

  assign push_req = (src != SRC_NONE);
  assign pop      = !empty && m_ready;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  sync_fifo #(
    .Width ($bits(rx_entry_t)),
    .Depth (Depth)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (rd_entry),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  assign m_valid     = !empty;
  assign m_data      = rd_entry.data[DataBits-1:0];
  assign m_error     = rd_entry.err;
  assign m_break     = rd_entry.brk;
  assign almost_full = (level >= LW'(Watermark));
  // Upper data bits are zero padding when DataBits < MaxDataBits.
  assign unused_rd   = ^rd_entry.data;

  // A drop in the same cycle as a clear wins, so no loss goes unreported.
  always_comb begin
    overflow_d = overflow_q;
    if (overflow_clear) overflow_d = 1'b0;
    if (drop)           overflow_d = 1'b1;
  end

  always_comb begin
    idle_d = idle_q;
    if (push || pop || empty)
      idle_d = '0;
    else if (idle_q != TW'(TimeoutCycles))
      idle_d = idle_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
      idle_q     <= '0;
    end else begin
      overflow_q <= overflow_d;
      idle_q     <= idle_d;
    end
  end

  assign overflow     = overflow_q;
  assign char_timeout = (idle_q == TW'(TimeoutCycles)) && !empty;

endmodule
